// File: rtl/mem_line_cache.sv
// Direct-mapped write-back row cache in front of a single-port synchronous BRAM.
// Rows never written back read as zero; flush writes back all dirty lines.
module mem_line_cache #(
  parameter int ROW_W     = 8,
  parameter int DEPTH     = 256,
  parameter int COL_W     = 3,
  parameter int TX_W      = 16,
  parameter int LINE_W    = 129,
  parameter int NUM_LINES = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_write,
  input  logic             req_pad,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic [TX_W-1:0]  req_wdata,
  input  logic             flush_req,
  output logic             resp_ack,
  output logic [TX_W-1:0]  resp_rdata,
  output logic             busy,
  output logic             flush_done
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {IDLE, EVICT, FILL, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [LINE_W-1:0]      line_q [NUM_LINES];
  logic [ROW_W-1:0]       tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid_q, dirty_q;
  logic [DEPTH-1:0]       written_q;
  logic [IDX_W-1:0]       flush_ptr;

  logic [LINE_W-1:0]      bram [DEPTH];
  logic [LINE_W-1:0]      bram_rdata, bram_wdata;
  logic [ROW_W-1:0]       bram_addr;
  logic                   bram_we, bram_re;

  logic [IDX_W-1:0]       idx, clean_idx;
  logic                   hit, victim_dirty, do_op, do_fill, flush_end;
  int                     off;
  logic [LINE_W-1:0]      wr_mask, wr_bits;
  logic [TX_W-1:0]        rd_slot;

  always_comb begin
    idx          = (NUM_LINES > 1) ? IDX_W'(req_row) : '0;
    hit          = valid_q[idx] && (tag_q[idx] == req_row);
    victim_dirty = valid_q[idx] && dirty_q[idx];
    off          = int'(req_col) * TX_W;
    wr_mask      = LINE_W'({TX_W{1'b1}}) << (off + int'(req_pad));
    wr_bits      = LINE_W'(req_wdata) << (off + int'(req_pad));
    rd_slot      = TX_W'(line_q[idx] >> off);
    flush_end    = (state_q == FLUSH) && (flush_ptr == IDX_W'(NUM_LINES - 1));
  end

  always_comb begin
    state_d    = state_q;
    bram_we    = 1'b0;
    bram_re    = 1'b0;
    bram_addr  = req_row;
    bram_wdata = line_q[idx];
    clean_idx  = idx;
    do_op      = 1'b0;
    do_fill    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !resp_ack) begin
          if (hit) begin
            do_op = 1'b1;
          end else if (victim_dirty) begin
            state_d = EVICT;
          end else begin
            bram_re = 1'b1;
            state_d = FILL;
          end
        end else if (flush_req) begin
          state_d = FLUSH;
        end
      end
      EVICT: begin
        bram_we   = 1'b1;
        bram_addr = tag_q[idx];
        // A never-written target fills with zeros, so the BRAM read cycle is skipped.
        state_d   = written_q[req_row] ? IDLE : FILL;
      end
      FILL: begin
        do_fill = 1'b1;
        state_d = IDLE;
      end
      FLUSH: begin
        clean_idx  = flush_ptr;
        bram_addr  = tag_q[flush_ptr];
        bram_wdata = line_q[flush_ptr];
        bram_we    = valid_q[flush_ptr] && dirty_q[flush_ptr];
        if (flush_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      written_q  <= '0;
      flush_ptr  <= '0;
      resp_ack   <= 1'b0;
      resp_rdata <= '0;
      flush_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        line_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      resp_ack   <= do_op;
      flush_done <= flush_end;
      if (do_op) begin
        if (req_write) begin
          line_q[idx]  <= (line_q[idx] & ~wr_mask) | wr_bits;
          dirty_q[idx] <= 1'b1;
        end else begin
          resp_rdata <= rd_slot;
        end
      end
      if (do_fill) begin
        line_q[idx]  <= written_q[req_row] ? bram_rdata : '0;
        tag_q[idx]   <= req_row;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (bram_we) begin
        written_q[bram_addr] <= 1'b1;
        dirty_q[clean_idx]   <= 1'b0;
      end
      if (state_q == FLUSH) flush_ptr <= flush_end ? '0 : flush_ptr + IDX_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (bram_we) bram[bram_addr] <= bram_wdata;
    else if (bram_re) bram_rdata <= bram[bram_addr];
  end

  assign busy = reset_n && (req_valid || (state_q != IDLE));

endmodule

// File: tb/tb_mem_line_cache.sv
// Directed self-checking bench for mem_line_cache: latencies, pad writes,
// eviction, flush and reset-abort behaviour.
module tb_mem_line_cache;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_pad = 1'b0;
  logic [7:0]  req_row = '0;
  logic [2:0]  req_col = '0;
  logic [15:0] req_wdata = '0;
  logic        flush_req = 1'b0;
  logic        resp_ack, busy, flush_done;
  logic [15:0] resp_rdata;

  int checks = 0;
  int failures = 0;

  mem_line_cache #(.ROW_W(8), .DEPTH(256), .COL_W(3), .TX_W(16), .LINE_W(129), .NUM_LINES(4)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
    .req_pad(req_pad), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .flush_req(flush_req), .resp_ack(resp_ack), .resp_rdata(resp_rdata),
    .busy(busy), .flush_done(flush_done)
  );

  always #5 clock = ~clock;

  task automatic apply_reset();
    req_valid = 1'b0;
    flush_req = 1'b0;
    reset_n   = 1'b0;
    #12;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Issues one request; lat = edges from acceptance edge to visible ack, -1 on timeout.
  task automatic do_req(input logic w, input logic pad, input logic [7:0] row,
                        input logic [2:0] col, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd);
    bit got = 0;
    @(negedge clock);
    for (int k = 0; k < 10 && resp_ack; k++) @(negedge clock);
    req_write = w; req_pad = pad; req_row = row; req_col = col; req_wdata = wd;
    req_valid = 1'b1;
    lat = 0;
    rd  = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      lat++;
      if (resp_ack) begin
        got = 1;
        rd  = resp_rdata;
      end
    end
    req_valid = 1'b0;
    if (!got) lat = -1;
  endtask

  // Raises flush_req and counts edges until flush_done; -1 on timeout.
  task automatic run_flush(output int n, output logic busy_seen);
    bit got = 0;
    @(negedge clock);
    flush_req = 1'b1;
    n = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) flush_req = 1'b0;
      if (n == 2) busy_seen = busy;
      if (flush_done) got = 1;
    end
    if (!got) n = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (resp_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", resp_ack); end
    checks++; if (resp_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", resp_rdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done got=%b exp=0", flush_done); end
    apply_reset();
  endtask

  task automatic test_clean_miss();
    int lat; logic [15:0] rd;
    do_req(1'b0, 1'b0, 8'd5, 3'd2, 16'h0, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL clean_miss_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL clean_miss_rdata got=%h exp=0000", rd); end
  endtask

  task automatic test_write_hit();
    int lat; logic [15:0] rd;
    apply_reset();
    do_req(1'b1, 1'b0, 8'd5, 3'd2, 16'hBEEF, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL write_miss_lat got=%0d exp=3", lat); end
    do_req(1'b0, 1'b0, 8'd5, 3'd2, 16'h0, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL read_hit_lat got=%0d exp=1", lat); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL read_hit_rdata got=%h exp=beef", rd); end
  endtask

  task automatic test_dirty_evict();
    int lat; logic [15:0] rd;
    do_req(1'b0, 1'b0, 8'd9, 3'd2, 16'h0, lat, rd);
    checks++; if (lat !== 4) begin failures++; $display("FAIL evict_lat got=%0d exp=4", lat); end
    checks++; if (rd !== 16'h0000) begin failures++; $display("FAIL evict_rdata got=%h exp=0000", rd); end
    do_req(1'b0, 1'b0, 8'd5, 3'd2, 16'h0, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL refill_lat got=%0d exp=3", lat); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL refill_rdata got=%h exp=beef", rd); end
  endtask

  task automatic test_pad_write();
    int lat; logic [15:0] rd;
    do_req(1'b1, 1'b1, 8'd5, 3'd0, 16'h8001, lat, rd);
    checks++; if (lat !== 1) begin failures++; $display("FAIL pad_write_lat got=%0d exp=1", lat); end
    do_req(1'b0, 1'b1, 8'd5, 3'd0, 16'h0, lat, rd);
    checks++; if (rd !== 16'h0002) begin failures++; $display("FAIL pad_col0 got=%h exp=0002", rd); end
    do_req(1'b0, 1'b0, 8'd5, 3'd1, 16'h0, lat, rd);
    checks++; if (rd !== 16'h0001) begin failures++; $display("FAIL pad_col1 got=%h exp=0001", rd); end
    do_req(1'b0, 1'b0, 8'd5, 3'd2, 16'h0, lat, rd);
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL pad_col2 got=%h exp=beef", rd); end
  endtask

  task automatic test_flush();
    int lat, n; logic [15:0] rd; logic bs;
    apply_reset();
    do_req(1'b1, 1'b0, 8'd4, 3'd0, 16'h1111, lat, rd);
    do_req(1'b1, 1'b0, 8'd6, 3'd0, 16'h2222, lat, rd);
    do_req(1'b0, 1'b0, 8'd7, 3'd0, 16'h0, lat, rd);
    run_flush(n, bs);
    checks++; if (n !== 5) begin failures++; $display("FAIL flush_latency got=%0d exp=5", n); end
    checks++; if (bs !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", bs); end
    @(posedge clock); #1;
    checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL flush_done_pulse got=%b exp=0", flush_done); end
    do_req(1'b0, 1'b0, 8'd4, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 1 || rd !== 16'h1111) begin failures++; $display("FAIL flush_reread4 lat=%0d rd=%h exp 1/1111", lat, rd); end
    do_req(1'b0, 1'b0, 8'd6, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 1 || rd !== 16'h2222) begin failures++; $display("FAIL flush_reread6 lat=%0d rd=%h exp 1/2222", lat, rd); end
    do_req(1'b1, 1'b0, 8'd8, 3'd0, 16'h3333, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL flush_clean_victim_lat got=%0d exp=3", lat); end
    do_req(1'b0, 1'b0, 8'd4, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 5 || rd !== 16'h1111) begin failures++; $display("FAIL flush_bram_data lat=%0d rd=%h exp 5/1111", lat, rd); end
    do_req(1'b0, 1'b0, 8'd11, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 3 || rd !== 16'h0000) begin failures++; $display("FAIL flush_unwritten lat=%0d rd=%h exp 3/0000", lat, rd); end
  endtask

  task automatic test_reset_evict();
    int lat; logic [15:0] rd;
    apply_reset();
    do_req(1'b1, 1'b0, 8'd3, 3'd1, 16'h1234, lat, rd);
    @(negedge clock);
    req_write = 1'b0; req_row = 8'd7; req_col = 3'd1; req_valid = 1'b1;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL evict_busy got=%b exp=1", busy); end
    #1;
    reset_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++; if (resp_ack !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0 || resp_rdata !== 16'h0)
      begin failures++; $display("FAIL abort_outputs ack=%b busy=%b fd=%b rd=%h exp all 0", resp_ack, busy, flush_done, resp_rdata); end
    @(negedge clock);
    reset_n = 1'b1;
    do_req(1'b0, 1'b0, 8'd3, 3'd1, 16'h0, lat, rd);
    checks++; if (lat !== 3 || rd !== 16'h0000) begin failures++; $display("FAIL abort_reread lat=%0d rd=%h exp 3/0000", lat, rd); end
  endtask

  task automatic test_req_flush_priority();
    int lat, n; logic [15:0] rd; bit got = 0;
    apply_reset();
    do_req(1'b1, 1'b0, 8'd1, 3'd0, 16'h5555, lat, rd);
    @(negedge clock);
    @(negedge clock);
    req_write = 1'b0; req_row = 8'd1; req_col = 3'd0; req_valid = 1'b1; flush_req = 1'b1;
    @(posedge clock); #1;
    checks++; if (resp_ack !== 1'b1 || resp_rdata !== 16'h5555 || flush_done !== 1'b0)
      begin failures++; $display("FAIL prio_ack ack=%b rd=%h fd=%b exp 1/5555/0", resp_ack, resp_rdata, flush_done); end
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clock); #1;
      n++;
      if (n == 1) flush_req = 1'b0;
      if (flush_done) got = 1;
    end
    flush_req = 1'b0;
    if (!got) n = -1;
    checks++; if (n !== 5) begin failures++; $display("FAIL prio_flush_after_ack got=%0d exp=5", n); end
    do_req(1'b0, 1'b0, 8'd5, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 3) begin failures++; $display("FAIL prio_line_clean_lat got=%0d exp=3", lat); end
    do_req(1'b0, 1'b0, 8'd1, 3'd0, 16'h0, lat, rd);
    checks++; if (lat !== 3 || rd !== 16'h5555) begin failures++; $display("FAIL prio_flushed_data lat=%0d rd=%h exp 3/5555", lat, rd); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_evict();
    test_pad_write();
    test_flush();
    test_reset_evict();
    test_req_flush_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
